// File: rtl/conv_tile_sched.sv
// Tile sequencer feeding one PE controller: per-pixel conv_en bursts, row drain gaps,
// pixel-boundary stalls on buff_full, force_wb at tile end. Optional SCHED_PERF_CNT_EN adds stall_cnt.
module conv_tile_sched #(
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned CYC_W     = 3,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CYC_W-1:0] cfg_stride_cycle,
    input  logic [IDX_W-1:0] cfg_out_cols,
    input  logic [IDX_W-1:0] cfg_out_rows,
    input  logic             buff_full,
    output logic             conv_en,
    output logic [CYC_W-1:0] stride_cycle,
    output logic             force_wb,
    output logic             busy,
    output logic             done,
`ifdef SCHED_PERF_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic [IDX_W-1:0] col_idx,
    output logic [IDX_W-1:0] row_idx
);

    localparam int unsigned DRN_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {IDLE, RUN, STALL, DRAIN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] vec_cnt_q, stride_q;
    logic [DRN_W-1:0] drain_cnt_q;
    logic [IDX_W-1:0] cols_q, rows_q, col_q, row_q;
    logic             conv_en_q, force_wb_q, busy_q, done_q, done_d;
    logic             pix_end, last_col, last_row, drain_end, zero_cfg;

    assign pix_end   = (vec_cnt_q == stride_q);
    assign last_col  = (col_q == cols_q - IDX_W'(1));
    assign last_row  = (row_q == rows_q - IDX_W'(1));
    assign drain_end = (drain_cnt_q == DRN_W'(DRAIN_CYC));
    assign zero_cfg  = (cfg_out_cols == '0) || (cfg_out_rows == '0);

    // Next-state decision; stalls are only taken at pixel or row boundaries.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_cfg) done_d  = 1'b1;
                    else          state_d = buff_full ? STALL : RUN;
                end
            end
            RUN: begin
                if (pix_end) begin
                    if (last_col)       state_d = DRAIN;
                    else if (buff_full) state_d = STALL;
                end
            end
            STALL: if (!buff_full) state_d = RUN;
            DRAIN: begin
                if (drain_end) begin
                    if (last_row) state_d = FLUSH;
                    else          state_d = buff_full ? STALL : RUN;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_cnt_q   <= '0;
            stride_q    <= '0;
            drain_cnt_q <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            conv_en_q   <= 1'b0;
            force_wb_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
            stall_cnt   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            conv_en_q  <= (state_d == RUN);
            busy_q     <= (state_d != IDLE);
            force_wb_q <= (state_d == FLUSH);
            done_q     <= done_d;
            case (state_q)
                IDLE: begin
                    if (start && !zero_cfg) begin
                        stride_q  <= (cfg_stride_cycle == '0) ? CYC_W'(1) : cfg_stride_cycle;
                        cols_q    <= cfg_out_cols;
                        rows_q    <= cfg_out_rows;
                        col_q     <= '0;
                        row_q     <= '0;
                        vec_cnt_q <= CYC_W'(1);
`ifdef SCHED_PERF_CNT_EN
                        stall_cnt <= '0;
`endif
                    end
                end
                RUN: begin
                    if (pix_end) begin
                        vec_cnt_q <= CYC_W'(1);
                        if (last_col) begin
                            col_q       <= '0;
                            drain_cnt_q <= DRN_W'(1);
                        end else begin
                            col_q <= col_q + IDX_W'(1);
                        end
                    end else begin
                        vec_cnt_q <= vec_cnt_q + CYC_W'(1);
                    end
                end
                STALL: begin
`ifdef SCHED_PERF_CNT_EN
                    if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
                end
                DRAIN: begin
                    if (drain_end) begin
                        if (!last_row) row_q <= row_q + IDX_W'(1);
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRN_W'(1);
                    end
                end
                FLUSH: begin
                    col_q <= '0;
                    row_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign conv_en      = conv_en_q;
    assign stride_cycle = stride_q;
    assign force_wb     = force_wb_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign col_idx      = col_q;
    assign row_idx      = row_q;

endmodule
